// File: rtl/bsg_tx_sequencer_if.sv
// Register-side and serial-side signal bundle for the BSG transmit sequencer.
// The master drives control/data bytes; the slave (sequencer) drives status and serial outputs.
interface bsg_tx_sequencer_if;
  logic       tx_enable;
  logic       int_mask;
  logic       int_flag_clr;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       bit_out;
  logic       bit_valid;
  logic       status;
  logic       int_flag;
  logic       done;

  modport master (
    output tx_enable, int_mask, int_flag_clr, data1, data2,
    input  bit_out, bit_valid, status, int_flag, done
  );

  modport slave (
    input  tx_enable, int_mask, int_flag_clr, data1, data2,
    output bit_out, bit_valid, status, int_flag, done
  );
endinterface

// File: rtl/bsg_tx_sequencer.sv
// Sequences one 16-bit BSG transmission (data1 then data2, MSB-first) on a rising
// edge of TXENABLE, holding each bit DIV cycles and reporting STATUS/INTFLAG/done.
module bsg_tx_sequencer #(
  parameter int unsigned DIV        = 4,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  bsg_tx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] shreg;
  logic [3:0]  bitcnt;
  logic [7:0]  divcnt;
  logic        tx_en_prev;
  logic        tx_armed;
  logic        start;
  logic        bit_end;
  logic        int_flag;

  // A level held high out of reset is not an edge: a low sample must be seen first.
  assign start   = bus.tx_enable & ~tx_en_prev & tx_armed;
  assign bit_end = (divcnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.bit_out   = IDLE_LEVEL;
    bus.bit_valid = 1'b0;
    bus.status    = 1'b0;
    bus.done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.status = 1'b1;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        bus.status    = 1'b1;
        bus.bit_out   = shreg[15];
        bus.bit_valid = 1'b1;
        if (bit_end && (bitcnt == 4'd15)) state_nxt = DONE;
      end
      DONE: begin
        bus.status = 1'b1;
        bus.done   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= 16'd0;
      bitcnt <= 4'd0;
      divcnt <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          shreg  <= {bus.data1, bus.data2};
          bitcnt <= 4'd0;
          divcnt <= 8'd0;
        end
        SHIFT: begin
          if (bit_end) begin
            shreg  <= {shreg[14:0], 1'b0};
            divcnt <= 8'd0;
            if (bitcnt != 4'd15) bitcnt <= bitcnt + 4'd1;
          end else begin
            divcnt <= divcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_prev <= 1'b0;
      tx_armed   <= 1'b0;
    end else begin
      tx_en_prev <= bus.tx_enable;
      tx_armed   <= tx_armed | ~bus.tx_enable;
    end
  end

  // Setting in the DONE cycle takes priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_flag <= 1'b0;
    end else if ((state == DONE) && bus.int_mask) begin
      int_flag <= 1'b1;
    end else if (bus.int_flag_clr) begin
      int_flag <= 1'b0;
    end
  end

  assign bus.int_flag = int_flag;

endmodule

// File: tb/tb_bsg_tx_sequencer.sv
// Drives two sequencers (DIV=4 and DIV=1) with shared stimulus and scores them against
// a transfer-level reference model: expected bits are queued per transfer and popped on bit_valid.
module tb_bsg_tx_sequencer;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable;
  logic       int_mask;
  logic       int_flag_clr;
  logic [7:0] data1;
  logic [7:0] data2;

  bsg_tx_sequencer_if bus0 ();
  bsg_tx_sequencer_if bus1 ();

  assign bus0.tx_enable    = tx_enable;
  assign bus0.int_mask     = int_mask;
  assign bus0.int_flag_clr = int_flag_clr;
  assign bus0.data1        = data1;
  assign bus0.data2        = data2;
  assign bus1.tx_enable    = tx_enable;
  assign bus1.int_mask     = int_mask;
  assign bus1.int_flag_clr = int_flag_clr;
  assign bus1.data1        = data1;
  assign bus1.data2        = data2;

  bsg_tx_sequencer #(.DIV(DIV0), .IDLE_LEVEL(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  bsg_tx_sequencer #(.DIV(DIV1), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  logic o_bit [2];
  logic o_vld [2];
  logic o_st  [2];
  logic o_flag[2];
  logic o_done[2];
  assign o_bit[0]  = bus0.bit_out;
  assign o_bit[1]  = bus1.bit_out;
  assign o_vld[0]  = bus0.bit_valid;
  assign o_vld[1]  = bus1.bit_valid;
  assign o_st[0]   = bus0.status;
  assign o_st[1]   = bus1.status;
  assign o_flag[0] = bus0.int_flag;
  assign o_flag[1] = bus1.int_flag;
  assign o_done[0] = bus0.done;
  assign o_done[1] = bus1.done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: busy = number of remaining status-high cycles of the current transfer.
  int   busy[2];
  bit   armed[2];
  bit   prev[2];
  bit   flag[2];
  logic bq0[$];
  logic bq1[$];

  int stat_cnt[2];
  int done_cnt[2];
  int vld_cnt[2];

  function automatic int divk(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      stat_cnt[k] = 0;
      done_cnt[k] = 0;
      vld_cnt[k]  = 0;
    end
  endtask

  task automatic push_bits(input int k, input logic [15:0] word, input int d);
    for (int i = 15; i >= 0; i--) begin
      for (int j = 0; j < d; j++) begin
        if (k == 0) bq0.push_back(word[i]);
        else        bq1.push_back(word[i]);
      end
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int d;
        d = divk(k);
        if (rst) begin
          busy[k]  = 0;
          armed[k] = 1'b0;
          prev[k]  = 1'b0;
          flag[k]  = 1'b0;
          if (k == 0) bq0.delete();
          else        bq1.delete();
        end else begin
          if (busy[k] == 1 && int_mask) flag[k] = 1'b1;
          else if (int_flag_clr)        flag[k] = 1'b0;
          if (busy[k] == 16 * d + 2) push_bits(k, {data1, data2}, d);
          if (busy[k] > 0) busy[k]--;
          else if (tx_enable && !prev[k] && armed[k]) busy[k] = 16 * d + 2;
          if (!tx_enable) armed[k] = 1'b1;
          prev[k] = tx_enable;
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          int   b;
          int   d;
          logic e;
          b = busy[k];
          d = divk(k);
          check("status", k, o_st[k], (b > 0));
          check("bit_valid", k, o_vld[k], (b >= 2 && b <= 16 * d + 1));
          check("done", k, o_done[k], (b == 1));
          check("int_flag", k, o_flag[k], flag[k]);
          if (o_st[k])   stat_cnt[k]++;
          if (o_done[k]) done_cnt[k]++;
          if (o_vld[k] === 1'b1) begin
            vld_cnt[k]++;
            if ((k == 0 && bq0.size() == 0) || (k == 1 && bq1.size() == 0)) begin
              check("bit_queue_underrun", k, 1, 0);
            end else begin
              e = (k == 0) ? bq0.pop_front() : bq1.pop_front();
              check("bit_out", k, o_bit[k], e);
            end
          end else begin
            check("bit_idle_level", k, o_bit[k], 1'b1);
          end
        end
      end
    end
  endtask

  task automatic wait_busy(input int k, input int val, input int budget);
    for (int i = 0; i < budget && busy[k] != val; i++) step();
    if (busy[k] != val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout dut%0d: busy %0d, wanted %0d", k, busy[k], val);
    end
  endtask

  task automatic wait_idle();
    wait_busy(0, 0, 200);
    wait_busy(1, 0, 200);
  endtask

  task automatic pulse_en();
    tx_enable = 1'b1;
    step();
    tx_enable = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_status"}, k, o_st[k], 1'b0);
      check({tag, "_bit_out"}, k, o_bit[k], 1'b1);
      check({tag, "_bit_valid"}, k, o_vld[k], 1'b0);
      check({tag, "_done"}, k, o_done[k], 1'b0);
      check({tag, "_int_flag"}, k, o_flag[k], 1'b0);
    end
  endtask

  initial begin
    tx_enable    = 1'b0;
    int_mask     = 1'b0;
    int_flag_clr = 1'b0;
    data1        = 8'h00;
    data2        = 8'h00;
    rst          = 1'b1;
    clear_counts();
    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset values
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Basic transfer A5/3C, interrupts masked
    clear_counts();
    data1 = 8'hA5;
    data2 = 8'h3C;
    pulse_en();
    wait_idle();
    repeat (3) step();
    check("t1_status_cycles", 0, stat_cnt[0], 66);
    check("t1_valid_cycles", 0, vld_cnt[0], 64);
    check("t1_done_count", 0, done_cnt[0], 1);
    check("t1_status_cycles", 1, stat_cnt[1], 18);
    check("t1_done_count", 1, done_cnt[1], 1);
    check("t1_int_flag", 0, o_flag[0], 1'b0);

    // Interrupt flag set, cleared, and set-over-clear in the DONE cycle
    int_mask = 1'b1;
    pulse_en();
    wait_idle();
    step();
    check("t2_flag_set", 0, o_flag[0], 1'b1);
    int_flag_clr = 1'b1;
    step();
    int_flag_clr = 1'b0;
    step();
    check("t2_flag_cleared", 0, o_flag[0], 1'b0);
    pulse_en();
    wait_busy(0, 1, 100);
    int_flag_clr = 1'b1;
    step();
    int_flag_clr = 1'b0;
    check("t2_set_beats_clear", 0, o_flag[0], 1'b1);
    int_flag_clr = 1'b1;
    step();
    int_flag_clr = 1'b0;
    int_mask = 1'b0;
    wait_idle();

    // Data changes and tx_enable toggles during SHIFT
    clear_counts();
    data1 = 8'hA5;
    data2 = 8'h3C;
    pulse_en();
    data1 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      repeat (3) step();
      tx_enable = ~tx_enable;
    end
    tx_enable = 1'b0;
    wait_idle();
    repeat (2) step();
    check("t3_single_done", 0, done_cnt[0], 1);

    // Asynchronous reset at bit 7, tx_enable held high through release
    data1 = 8'h5A;
    tx_enable = 1'b1;
    wait_busy(0, 37, 100);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step();
    step();
    rst = 1'b0;
    clear_counts();
    repeat (10) step();
    check("t4_no_start_held_high", 0, stat_cnt[0], 0);
    check("t4_no_start_held_high", 1, stat_cnt[1], 0);
    tx_enable = 1'b0;
    step();
    pulse_en();
    wait_idle();
    repeat (2) step();
    check("t4_restart_done", 0, done_cnt[0], 1);

    // DIV=1 with a rising edge in the cycle right after DONE
    clear_counts();
    data1 = 8'h01;
    data2 = 8'h80;
    pulse_en();
    wait_busy(1, 1, 50);
    tx_enable = 1'b0;
    step();
    tx_enable = 1'b1;
    step();
    check("t5_back_to_back_load", 1, o_st[1], 1'b1);
    tx_enable = 1'b0;
    wait_idle();
    repeat (2) step();
    check("t5_done_count", 1, done_cnt[1], 2);
    check("t5_status_cycles", 1, stat_cnt[1], 36);
    check("t5_valid_cycles", 1, vld_cnt[1], 32);
    check("t5_div4_ignored_edge", 0, done_cnt[0], 1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      data1        = 8'($urandom);
      data2        = 8'($urandom);
      int_mask     = 1'($urandom_range(0, 1));
      tx_enable    = 1'($urandom_range(0, 1));
      int_flag_clr = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 20)) step();
    end
    tx_enable    = 1'b0;
    int_flag_clr = 1'b0;
    wait_idle();
    repeat (3) step();
    check("bits_left_over", 0, bq0.size(), 0);
    check("bits_left_over", 1, bq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
